// File: rtl/line_fill_ctrl_if.sv
// Bus bundle for line_fill_ctrl: fill request, host port, char/chardata RAM and line-RAM ports.
// Optional overrun_cnt present only when LINE_FILL_OVERRUN_CNT_EN is defined.
interface line_fill_ctrl_if;
    logic        line_start;
    logic [9:0]  line_y;
    logic        bank;
    logic        host_req;
    logic [11:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_gnt;
    logic [11:0] char_addr;
    logic        char_we;
    logic [7:0]  char_wdata;
    logic [7:0]  glyph_data;
    logic [11:0] pix_addr;
    logic [7:0]  pix_data;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic [7:0]  lb_wdata;
    logic        busy;
    logic        done;
    logic        overrun;
`ifdef LINE_FILL_OVERRUN_CNT_EN
    logic [7:0]  overrun_cnt;
`endif

    modport master (
`ifdef LINE_FILL_OVERRUN_CNT_EN
        output overrun_cnt,
`endif
        input  line_start, line_y, bank,
        input  host_req, host_addr, host_wdata,
        output host_gnt,
        output char_addr, char_we, char_wdata,
        input  glyph_data,
        output pix_addr,
        input  pix_data,
        output lb_we, lb_addr, lb_wdata,
        output busy, done, overrun
    );

    modport slave (
`ifdef LINE_FILL_OVERRUN_CNT_EN
        input  overrun_cnt,
`endif
        output line_start, line_y, bank,
        output host_req, host_addr, host_wdata,
        input  host_gnt,
        input  char_addr, char_we, char_wdata,
        output glyph_data,
        input  pix_addr,
        output pix_data,
        input  lb_we, lb_addr, lb_wdata,
        input  busy, done, overrun
    );
endinterface

// File: rtl/line_fill_ctrl.sv
// Per-line fill scheduler: char_ram -> chardata_ram -> line RAM, with host char_ram arbitration.
// Define LINE_FILL_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module line_fill_ctrl #(
    parameter int LINE_PIXELS = 512,
    parameter int COL_W       = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    line_fill_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_PIXELS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [COL_W-1:0] r_col;
    logic             r_drain_cnt;
    logic             r_s1_v;
    logic             r_s2_v;
    logic [COL_W-1:0] r_s1_col;
    logic [COL_W-1:0] r_s2_col;
    logic             r_bank;
    logic [8:0]       r_y;
    logic             r_done;

    logic             w_idle;
    logic             w_fill;
    logic             w_busy;
    logic             w_accept;
    logic             w_last;
    logic             w_drain_end;
    logic             w_gnt;
    logic             w_ovr;
    logic [5:0]       w_tile;
    logic [1:0]       w_pix2;

    assign w_idle      = (r_state == S_IDLE);
    assign w_fill      = (r_state == S_FILL);
    assign w_busy      = ~w_idle;
    assign w_accept    = w_idle & bus.line_start;
    assign w_last      = w_fill & (r_col == LAST_COL);
    assign w_drain_end = (r_state == S_DRAIN) & r_drain_cnt;
    assign w_gnt       = w_idle & bus.host_req & ~bus.line_start;
    assign w_ovr       = w_busy & bus.line_start;
    assign w_tile      = 6'(r_col >> 3);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.line_start) w_next = S_FILL;
            S_FILL:  if (w_last)         w_next = S_DRAIN;
            S_DRAIN: if (r_drain_cnt)    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_drain_cnt <= 1'b0;
            r_s1_v      <= 1'b0;
            r_s2_v      <= 1'b0;
            r_s1_col    <= '0;
            r_s2_col    <= '0;
            r_bank      <= 1'b0;
            r_y         <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_done      <= w_drain_end;
            r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
            if (w_accept) begin
                r_bank <= bus.bank;
                r_y    <= bus.line_y[8:0];
            end
            // Column returns to zero only through the FILL exit
            if (w_fill)
                r_col <= w_last ? '0 : r_col + 1'b1;
            r_s1_v   <= w_fill;
            r_s1_col <= r_col;
            r_s2_v   <= r_s1_v;
            r_s2_col <= r_s1_col;
        end
    end

    always_comb begin
        w_pix2 = 2'b00;
        unique case (r_s2_col[1:0])
            2'd0: w_pix2 = bus.pix_data[7:6];
            2'd1: w_pix2 = bus.pix_data[5:4];
            2'd2: w_pix2 = bus.pix_data[3:2];
            2'd3: w_pix2 = bus.pix_data[1:0];
            default: w_pix2 = 2'b00;
        endcase
    end

    // Host owns the char_ram port only on idle cycles without a fill request
    assign bus.host_gnt   = w_gnt;
    assign bus.char_we    = w_gnt;
    assign bus.char_wdata = w_gnt ? bus.host_wdata : 8'h00;
    assign bus.char_addr  = w_gnt  ? bus.host_addr :
                            w_fill ? {r_y[8:3], w_tile} : 12'h000;

    assign bus.pix_addr = r_s1_v ? {bus.glyph_data, r_y[2:0], r_s1_col[2]} : 12'h000;

    assign bus.lb_we    = r_s2_v;
    assign bus.lb_addr  = r_s2_v ? {r_bank, 9'(r_s2_col)} : 10'h000;
    assign bus.lb_wdata = r_s2_v ? {4{w_pix2}} : 8'h00;

    assign bus.busy    = w_busy;
    assign bus.done    = r_done;
    assign bus.overrun = w_ovr;

`ifdef LINE_FILL_OVERRUN_CNT_EN
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovr_cnt <= 8'h00;
        else if (w_ovr && (r_ovr_cnt != 8'hFF))
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end

    assign bus.overrun_cnt = r_ovr_cnt;
`endif

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Randomized bench for line_fill_ctrl against a timeline model of each fill.
// Directed runs pin the model with hand-computed literals.
module tb_line_fill_ctrl;
    localparam int N = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_fill_ctrl_if bus();

    line_fill_ctrl #(.LINE_PIXELS(N), .COL_W(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit fixed_data = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h need %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a fill accepted at negedge k issues column t on cycle k+1+t
    bit         m_act = 1'b0;
    int         m_s   = 0;
    logic [8:0] m_y   = '0;
    logic       m_b   = 1'b0;
    int         m_ovr = 0;
    int         t, j, p2;
    bit         e_busy;
    logic [11:0] e_caddr, e_paddr;
    logic        e_cwe, e_gnt, e_lbwe, e_done, e_ovr;
    logic [7:0]  e_cwd, e_lbwd;
    logic [9:0]  e_lba;

    always @(negedge clk) begin
        cyc++;
        e_caddr = '0; e_paddr = '0; e_cwe = 0; e_gnt = 0;
        e_lbwe = 0; e_done = 0; e_ovr = 0; e_cwd = '0;
        e_lbwd = '0; e_lba = '0; e_busy = 0;
        t = cyc - m_s;
        if (rst_n) begin
            e_busy = m_act && t >= 0 && t <= N + 1;
            if (e_busy && t <= N - 1)
                e_caddr = {m_y[8:3], 6'(t >> 3)};
            if (e_busy && t >= 1 && t <= N)
                e_paddr = {bus.glyph_data, m_y[2:0], 1'((t - 1) >> 2)};
            if (e_busy && t >= 2) begin
                j = t - 2;
                p2 = (int'(bus.pix_data) >> (6 - 2 * (j % 4))) & 3;
                e_lbwe = 1;
                e_lba = {m_b, 9'(j)};
                e_lbwd = 8'(p2 * 85);
            end
            e_done = m_act && t == N + 2;
            e_ovr = e_busy && bus.line_start;
            if (!e_busy && bus.host_req && !bus.line_start) begin
                e_gnt = 1; e_cwe = 1;
                e_caddr = bus.host_addr;
                e_cwd = bus.host_wdata;
            end
        end
        chk("busy", bus.busy, e_busy);
        chk("done", bus.done, e_done);
        chk("overrun", bus.overrun, e_ovr);
        chk("host_gnt", bus.host_gnt, e_gnt);
        chk("char_we", bus.char_we, e_cwe);
        chk("char_addr", bus.char_addr, e_caddr);
        chk("char_wdata", bus.char_wdata, e_cwd);
        chk("pix_addr", bus.pix_addr, e_paddr);
        chk("lb_we", bus.lb_we, e_lbwe);
        chk("lb_addr", bus.lb_addr, e_lba);
        chk("lb_wdata", bus.lb_wdata, e_lbwd);
`ifdef LINE_FILL_OVERRUN_CNT_EN
        chk("overrun_cnt", bus.overrun_cnt, m_ovr);
`endif
        if (!rst_n) begin
            m_act = 0;
            m_ovr = 0;
        end else begin
            if (e_ovr && m_ovr < 255) m_ovr++;
            if (!e_busy && bus.line_start) begin
                m_act = 1;
                m_s = cyc + 1;
                m_y = bus.line_y[8:0];
                m_b = bus.bank;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!fixed_data) begin
            bus.glyph_data = 8'($urandom);
            bus.pix_data   = 8'($urandom);
        end
    endtask

    task automatic run_fill(input int ovr_at, output int wc, output int dc, output int oc);
        tick();
        bus.line_y = 10'($urandom);
        bus.bank = 1'($urandom);
        bus.line_start = 1;
        tick();
        bus.line_start = 0;
        wc = 0; dc = 0; oc = 0;
        for (int i = 0; i < N + 6; i++) begin
            @(negedge clk);
            if (bus.lb_we) wc++;
            if (bus.done) dc++;
            if (bus.overrun) oc++;
            tick();
            bus.line_start = (i == ovr_at);
        end
    endtask

    initial begin
        logic [7:0] pat [4];
        logic [9:0] last_a;
        int wc, dc, oc, gc;
        pat[0] = 8'hFF; pat[1] = 8'hAA; pat[2] = 8'h55; pat[3] = 8'h00;
        bus.line_start = 0; bus.line_y = '0; bus.bank = 0;
        bus.host_req = 0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.glyph_data = '0; bus.pix_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Directed fill with fixed RAM data
        fixed_data = 1;
        tick();
        bus.line_y = 10'h013; bus.bank = 1;
        bus.glyph_data = 8'h41; bus.pix_data = 8'hE4;
        bus.line_start = 1;
        tick();
        bus.line_start = 0;
        wc = 0; dc = 0; last_a = '0;
        for (int i = 0; i < N + 6; i++) begin
            @(negedge clk);
            if (i == 0) chk("t1_char_addr", bus.char_addr, 12'h080);
            if (i == 1) chk("t1_pix_addr", bus.pix_addr, 12'h416);
            if (bus.lb_we) begin
                if (wc == 0) chk("t1_first_addr", bus.lb_addr, 10'h200);
                chk("t1_wdata", bus.lb_wdata, pat[wc % 4]);
                last_a = bus.lb_addr;
                wc++;
            end
            if (bus.done) dc++;
        end
        chk("t1_writes", wc, N);
        chk("t1_last_addr", last_a, 10'h3FF);
        chk("t1_done", dc, 1);
        fixed_data = 0;

        // Overrun during a fill
        run_fill(99, wc, dc, oc);
        chk("t2_writes", wc, N);
        chk("t2_done", dc, 1);
        chk("t2_overruns", oc, 1);

        // Host write in idle, then held across a fill
        tick();
        bus.host_req = 1; bus.host_addr = 12'h123; bus.host_wdata = 8'h5A;
        @(negedge clk);
        chk("t3_gnt", bus.host_gnt, 1);
        chk("t3_we", bus.char_we, 1);
        chk("t3_addr", bus.char_addr, 12'h123);
        chk("t3_wdata", bus.char_wdata, 8'h5A);
        tick();
        bus.line_start = 1;
        @(negedge clk);
        chk("t4_gnt", bus.host_gnt, 0);
        tick();
        bus.line_start = 0;
        gc = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            if (bus.host_gnt) gc++;
        end
        chk("t3_gnt_busy", gc, 0);
        @(negedge clk);
        chk("t3_done", bus.done, 1);
        chk("t3_gnt_after", bus.host_gnt, 1);
        tick();
        bus.host_req = 0;

        // Reset in the middle of a fill
        tick();
        bus.line_y = 10'($urandom); bus.line_start = 1;
        tick();
        bus.line_start = 0;
        repeat (201) tick();
        rst_n = 0;
        #1;
        chk("t5_lb_we", bus.lb_we, 0);
        chk("t5_busy", bus.busy, 0);
        tick();
        tick();
        rst_n = 1;
        dc = 0;
        for (int i = 0; i < N + 6; i++) begin
            @(negedge clk);
            if (bus.done) dc++;
        end
        chk("t5_no_done", dc, 0);
        run_fill(-1, wc, dc, oc);
        chk("t5_writes", wc, N);
        chk("t5_done", dc, 1);

        // line_start held high: back-to-back fills plus many overruns
        tick();
        bus.line_start = 1;
        dc = 0; oc = 0;
        for (int i = 0; i < 2 * N + 10; i++) begin
            @(negedge clk);
            if (bus.done) dc++;
            if (bus.overrun) oc++;
            tick();
        end
        bus.line_start = 0;
        chk("t6_done", dc, 2);
        chk("t6_overruns", oc, 2 * N + 7);
`ifdef LINE_FILL_OVERRUN_CNT_EN
        chk("t6_cnt_sat", bus.overrun_cnt, 8'hFF);
`endif
        repeat (N + 6) tick();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick();
            bus.line_start = ($urandom_range(0, 299) == 0);
            bus.line_y     = 10'($urandom);
            bus.bank       = 1'($urandom);
            bus.host_req   = 1'($urandom);
            bus.host_addr  = 12'($urandom);
            bus.host_wdata = 8'($urandom);
        end
        tick();
        bus.line_start = 0;
        bus.host_req = 0;
        repeat (N + 6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
